// File: rtl/tri_bus_arbiter.sv
// Round-robin owner sequencer for a shared tristate net with turnaround gap and tenure limit.
// Optional bus-park output enabled by defining TRI_BUS_ARB_PARK_EN.
module tri_bus_arbiter #(
  parameter int N          = 4,
  parameter int TURN_CYC   = 1,
  parameter int MAX_TENURE = 8,
  parameter int IDW        = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   drive_en,
  output logic [IDW-1:0] owner,
  output logic           busy,
  output logic           turn,
  output logic           expired,
  output logic           park_en
);

  localparam int TCW = (TURN_CYC > 1) ? $clog2(TURN_CYC + 1) : 1;
  localparam int TNW = (MAX_TENURE > 1) ? $clog2(MAX_TENURE + 1) : 1;
  localparam logic [TCW-1:0] TURN_LD  = TCW'(TURN_CYC);
  localparam logic [TNW-1:0] TEN_MAX  = TNW'(MAX_TENURE);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(N - 1);
  localparam logic [N-1:0]   ONE_HOT0 = N'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  // First set request at or above ptr, wrapping modulo N; MSB of the result flags a winner.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] ptr);
    logic           found;
    logic [IDW-1:0] idx;
    logic [IDW:0]   pos;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (IDW+1)'(i);
      if (pos >= (IDW+1)'(N)) begin
        pos = pos - (IDW+1)'(N);
      end else begin
        pos = pos;
      end
      if (!found && r[pos[IDW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IDW-1:0];
      end else begin
        idx = idx;
      end
    end
    return {found, idx};
  endfunction

  state_t         state_r, state_s;
  logic [IDW-1:0] rr_ptr_r, rr_ptr_s;
  logic [TNW-1:0] tenure_r, tenure_s;
  logic [TCW-1:0] turn_cnt_r, turn_cnt_s;
  logic [N-1:0]   grant_r, grant_s;
  logic [IDW-1:0] owner_r, owner_s;
  logic           busy_r, busy_s;
  logic           turn_r, turn_s;
  logic           expired_r, expired_s;
  logic           park_r, park_s;
  logic [IDW:0]   pick_s;

  // Next-state and next-output decode for the IDLE/OWN/TURN sequencer.
  always_comb begin
    state_s    = state_r;
    rr_ptr_s   = rr_ptr_r;
    tenure_s   = tenure_r;
    turn_cnt_s = turn_cnt_r;
    grant_s    = grant_r;
    owner_s    = owner_r;
    busy_s     = busy_r;
    turn_s     = turn_r;
    expired_s  = 1'b0;
    pick_s     = rr_pick(req, rr_ptr_r);
    case (state_r)
      IDLE: begin
        if (pick_s[IDW]) begin
          state_s  = OWN;
          grant_s  = ONE_HOT0 << pick_s[IDW-1:0];
          owner_s  = pick_s[IDW-1:0];
          busy_s   = 1'b1;
          turn_s   = 1'b0;
          tenure_s = TNW'(1);
        end else begin
          state_s = IDLE;
        end
      end
      OWN: begin
        // Expiry reuses the release path; expired only fires if the owner still wanted the bus.
        if (!req[owner_r] || ((MAX_TENURE != 0) && (tenure_r == TEN_MAX))) begin
          state_s    = TURN;
          grant_s    = '0;
          busy_s     = 1'b0;
          turn_s     = 1'b1;
          turn_cnt_s = TURN_LD;
          rr_ptr_s   = (owner_r == LAST_IDX) ? '0 : owner_r + IDW'(1);
          expired_s  = req[owner_r];
        end else if ((MAX_TENURE != 0) && (tenure_r != TEN_MAX)) begin
          tenure_s = tenure_r + TNW'(1);
        end else begin
          tenure_s = tenure_r;
        end
      end
      TURN: begin
        if (turn_cnt_r == TCW'(1)) begin
          turn_s = 1'b0;
          if (pick_s[IDW]) begin
            state_s  = OWN;
            grant_s  = ONE_HOT0 << pick_s[IDW-1:0];
            owner_s  = pick_s[IDW-1:0];
            busy_s   = 1'b1;
            tenure_s = TNW'(1);
          end else begin
            state_s = IDLE;
          end
        end else begin
          turn_cnt_s = turn_cnt_r - TCW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = '0;
        busy_s  = 1'b0;
        turn_s  = 1'b0;
      end
    endcase
`ifdef TRI_BUS_ARB_PARK_EN
    park_s = (state_s == IDLE);
`else
    park_s = 1'b0;
`endif
  end

  // State and output registers; async reset clears every enable immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      tenure_r   <= '0;
      turn_cnt_r <= '0;
      grant_r    <= '0;
      owner_r    <= '0;
      busy_r     <= 1'b0;
      turn_r     <= 1'b0;
      expired_r  <= 1'b0;
      park_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      rr_ptr_r   <= rr_ptr_s;
      tenure_r   <= tenure_s;
      turn_cnt_r <= turn_cnt_s;
      grant_r    <= grant_s;
      owner_r    <= owner_s;
      busy_r     <= busy_s;
      turn_r     <= turn_s;
      expired_r  <= expired_s;
      park_r     <= park_s;
    end
  end

  assign grant    = grant_r;
  assign drive_en = grant_r;
  assign owner    = owner_r;
  assign busy     = busy_r;
  assign turn     = turn_r;
  assign expired  = expired_r;
  assign park_en  = park_r;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter (N=4, TURN_CYC=1, MAX_TENURE=8), plus per-cycle invariants.
module tb_tri_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] drive_en;
  logic [1:0] owner;
  logic       busy;
  logic       turn;
  logic       expired;
  logic       park_en;

  int compared   = 0;
  int mismatched = 0;
  int cur;

`ifdef TRI_BUS_ARB_PARK_EN
  localparam logic PK = 1'b1;
`else
  localparam logic PK = 1'b0;
`endif

  tri_bus_arbiter #(.N(4), .TURN_CYC(1), .MAX_TENURE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant    (grant),
    .drive_en (drive_en),
    .owner    (owner),
    .busy     (busy),
    .turn     (turn),
    .expired  (expired),
    .park_en  (park_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [3:0] g, input logic [1:0] o,
                        input logic b, input logic t, input logic e, input logic p);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".drive_en"}, 32'(drive_en), 32'(g));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".turn"}, 32'(turn), 32'(t));
    chk({tag, ".expired"}, 32'(expired), 32'(e));
    chk({tag, ".park_en"}, 32'(park_en), 32'(p));
    if (b) chk({tag, ".owner"}, 32'(owner), 32'(o));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus-safety invariants sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_onehot", 32'($countones(drive_en) <= 1), 32'd1);
      chk("inv_drive_eq_grant", 32'(drive_en), 32'(grant));
      chk("inv_busy_eq_or_grant", 32'(busy), 32'(|grant));
      chk("inv_turn_busy_excl", 32'(turn && busy), 32'd0);
      chk("inv_park_vs_drive", 32'(park_en && (|drive_en)), 32'd0);
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    #2;
    chk_st("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.owner", 32'(owner), 32'd0);
    #5 rst_n = 1'b1;
    tick();
    chk_st("idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, PK);

    // Single requester, then release.
    req = 4'b0010;
    tick();
    chk_st("single_grant", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      tick();
      chk_st("single_hold", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    req = 4'b0000;
    tick();
    chk_st("single_release", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_st("single_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, PK);

    // Pointer now 2: owner 2 wins, then hands over to 3 across one gap cycle.
    req = 4'b1111;
    tick();
    chk_st("hand_own2", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_st("hand_own2_hold", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    req = 4'b1011;
    tick();
    chk_st("hand_gap", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_st("hand_own3", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);

    // All requesting: 8-cycle tenures, expiry pulse, rotation 3,0,1,2,3,0.
    req = 4'b1111;
    cur = 3;
    for (int r = 0; r < 5; r++) begin
      for (int k = 2; k <= 8; k++) begin
        tick();
        chk_st("rr_hold", 4'(1 << cur), 2'(cur), 1'b1, 1'b0, 1'b0, 1'b0);
      end
      tick();
      chk_st("rr_expire", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      cur = (cur + 1) % 4;
      chk_st("rr_next", 4'(1 << cur), 2'(cur), 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Sole requester 0 expires and re-wins after the turnaround.
    req = 4'b0001;
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk_st("ten_hold", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    tick();
    chk_st("ten_expire", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_st("ten_regrant", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges while owning.
    #2 rst_n = 1'b0;
    #1;
    chk_st("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("async_reset.owner", 32'(owner), 32'd0);
    req = 4'b0100;
    #2 rst_n = 1'b1;
    tick();
    chk_st("post_reset_grant", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Pointer wrap: 2 releases -> 3 wins, 3 releases -> pointer wraps, 0 wins.
    req = 4'b0000;
    tick();
    chk_st("wrap_rel2", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    req = 4'b1011;
    tick();
    chk_st("wrap_own3", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    req = 4'b0011;
    tick();
    chk_st("wrap_rel3", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_st("wrap_own0", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    req = 4'b0000;
    tick();
    chk_st("final_turn", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_st("final_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, PK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
